// File: rtl/logic_gate_pipe_pkg.sv
// Shared definitions for the pipelined gate unit: gate select codes and the
// width-agnostic gate function used by the result stage.
package logic_gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;
    localparam logic [2:0] OP_BUFA = 3'd7;

    // Callers zero-extend their operands and truncate the result back to WIDTH.
    localparam int unsigned GATE_MAX_W = 64;
    typedef logic [GATE_MAX_W-1:0] gate_word_t;

    function automatic gate_word_t gate_fn(input logic [2:0] op,
                                           input gate_word_t a,
                                           input gate_word_t b);
        gate_word_t r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NOTA: r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_gate_pipe_if.sv
// Operand/result handshake bundle of the gate unit plus its change-counter
// monitor signals; master drives operands, slave is the unit.
interface logic_gate_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             y_changed;
    logic             clr_cnt;
    logic [CNT_W-1:0] chg_cnt;

    modport master (
        output in_valid, a, b, op, out_ready, clr_cnt,
        input  in_ready, out_valid, y, y_changed, chg_cnt
    );

    modport slave (
        input  in_valid, a, b, op, out_ready, clr_cnt,
        output in_ready, out_valid, y, y_changed, chg_cnt
    );
endinterface

// File: rtl/logic_gate_pipe_stage.sv
// Generic valid/ready register slice: loads when empty or when its content is
// taken the same cycle, otherwise holds. Full throughput, no bubbles.
module logic_gate_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o
);
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          load;

    assign ready_o = ~valid_q | ready_i;
    assign load    = valid_i & ready_o;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    // NOTE: the data register is reset as well, because the result output must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage pipelined bitwise gate unit with valid/ready on both sides and a
// saturating counter of results that differ from their predecessor.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    logic_gate_pipe_if.slave gate_if
);
    localparam int               S1_W    = 3 + 2 * WIDTH;
    localparam int               S2_W    = 1 + WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid;
    logic             s2_ready;
    logic [S1_W-1:0]  s1_data;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic [WIDTH-1:0] f;
    logic             f_changed;
    logic             adv2;
    logic [S2_W-1:0]  s2_data;
    logic [WIDTH-1:0] prev_y_q, prev_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic_gate_stage #(.DW(S1_W)) u_stage1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (gate_if.in_valid),
        .ready_o (gate_if.in_ready),
        .data_i  ({gate_if.op, gate_if.b, gate_if.a}),
        .valid_o (s1_valid),
        .ready_i (s2_ready),
        .data_o  (s1_data)
    );

    assign {s1_op, s1_b, s1_a} = s1_data;

    assign f         = WIDTH'(gate_fn(s1_op, gate_word_t'(s1_a), gate_word_t'(s1_b)));
    assign f_changed = (f != prev_y_q);
    assign adv2      = s1_valid & s2_ready;

    logic_gate_stage #(.DW(S2_W)) u_stage2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (s1_valid),
        .ready_o (s2_ready),
        .data_i  ({f_changed, f}),
        .valid_o (gate_if.out_valid),
        .ready_i (gate_if.out_ready),
        .data_o  (s2_data)
    );

    assign {gate_if.y_changed, gate_if.y} = s2_data;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        prev_y_d = prev_y_q;
        cnt_d    = cnt_q;
        if (adv2) begin
            prev_y_d = f;
        end
        if (gate_if.clr_cnt) begin
            cnt_d = '0;
        end else if (adv2 && f_changed && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_y_q <= '0;
            cnt_q    <= '0;
        end else begin
            prev_y_q <= prev_y_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gate_if.chg_cnt = cnt_q;
endmodule

// File: tb/tb_logic_gate_pipe.sv
// Bench for logic_gate_pipe: unit 0 is WIDTH=8/CNT_W=16, unit 1 is WIDTH=1/CNT_W=2.
// A truth-table/occupancy model checks both units every cycle; directed tests pin literals.
module tb_logic_gate_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_gate_pipe_if #(.WIDTH(8), .CNT_W(16)) bus0 ();
    logic_gate_pipe_if #(.WIDTH(1), .CNT_W(2))  bus1 ();

    logic_gate_pipe #(.WIDTH(8), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .gate_if(bus0.slave));
    logic_gate_pipe #(.WIDTH(1), .CNT_W(2))  dut1 (.clk(clk), .rst_n(rst_n), .gate_if(bus1.slave));

    // Both units viewed through common 8/16-bit observation arrays.
    logic       o_in_valid [2], o_in_ready [2], o_out_valid [2], o_out_ready [2];
    logic       o_y_changed [2], o_clr [2];
    logic [7:0] o_a [2], o_b [2], o_y [2];
    logic [2:0] o_op [2];
    logic [15:0] o_cnt [2];

    assign o_in_valid[0] = bus0.in_valid;   assign o_in_valid[1] = bus1.in_valid;
    assign o_in_ready[0] = bus0.in_ready;   assign o_in_ready[1] = bus1.in_ready;
    assign o_out_valid[0] = bus0.out_valid; assign o_out_valid[1] = bus1.out_valid;
    assign o_out_ready[0] = bus0.out_ready; assign o_out_ready[1] = bus1.out_ready;
    assign o_y_changed[0] = bus0.y_changed; assign o_y_changed[1] = bus1.y_changed;
    assign o_clr[0] = bus0.clr_cnt;         assign o_clr[1] = bus1.clr_cnt;
    assign o_a[0] = bus0.a;                 assign o_a[1] = {7'd0, bus1.a};
    assign o_b[0] = bus0.b;                 assign o_b[1] = {7'd0, bus1.b};
    assign o_y[0] = bus0.y;                 assign o_y[1] = {7'd0, bus1.y};
    assign o_op[0] = bus0.op;               assign o_op[1] = bus1.op;
    assign o_cnt[0] = bus0.chg_cnt;         assign o_cnt[1] = {14'd0, bus1.chg_cnt};

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Truth table per op, bit index {a,b}.
    logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                           4'b0110, 4'b1001, 4'b0011, 4'b1100};

    function automatic logic [7:0] model_gate(input logic [2:0] op, input logic [7:0] a,
                                              input logic [7:0] b, input int w);
        logic [3:0] row;
        logic [7:0] r;
        row = tt[op];
        r   = '0;
        for (int k = 0; k < w; k++) r[k] = row[{a[k], b[k]}];
        return r;
    endfunction

    // Model: accepted beats queue up in order; the head is on the output from the
    // second sample after its acceptance; capacity is two beats.
    typedef struct {
        logic [7:0] y;
        logic       ch;
        int         acc_n;
        logic       counted;
    } ent_t;

    ent_t       fifo [2][128];
    int         wr [2], rd [2], m_cnt [2];
    logic [7:0] m_prev [2], acc_y [2];
    logic       acc_p [2], acc_ch [2], pop_p [2], clr_p [2];
    int         neg_n = 0;
    int         m_occ, m_idx, m_w, m_max;
    logic       m_vis, m_rdy;

    always @(negedge clk) begin
        neg_n = neg_n + 1;
        for (int i = 0; i < 2; i++) begin
            m_w   = (i == 0) ? 8 : 1;
            m_max = (i == 0) ? 65535 : 3;
            if (!rst_n) begin
                wr[i] = 0; rd[i] = 0; m_cnt[i] = 0; m_prev[i] = '0;
                acc_p[i] = 1'b0; pop_p[i] = 1'b0; clr_p[i] = 1'b0;
            end else begin
                if (pop_p[i]) rd[i] = rd[i] + 1;
                if (acc_p[i]) begin
                    m_idx = wr[i] % 128;
                    fifo[i][m_idx].y       = acc_y[i];
                    fifo[i][m_idx].ch      = acc_ch[i];
                    fifo[i][m_idx].acc_n   = neg_n - 1;
                    fifo[i][m_idx].counted = 1'b0;
                    wr[i] = wr[i] + 1;
                end
                m_occ = wr[i] - rd[i];
                m_idx = rd[i] % 128;
                m_vis = (m_occ > 0) && (neg_n >= fifo[i][m_idx].acc_n + 2);
                if (m_vis && !fifo[i][m_idx].counted) begin
                    fifo[i][m_idx].counted = 1'b1;
                    if (fifo[i][m_idx].ch && m_cnt[i] < m_max) m_cnt[i] = m_cnt[i] + 1;
                end
                if (clr_p[i]) m_cnt[i] = 0;
                m_rdy = !(m_occ == 2 && !o_out_ready[i]);

                check($sformatf("u%0d.out_valid", i), o_out_valid[i], m_vis);
                if (m_vis) begin
                    check($sformatf("u%0d.y", i), o_y[i], fifo[i][m_idx].y);
                    check($sformatf("u%0d.y_changed", i), o_y_changed[i], fifo[i][m_idx].ch);
                end
                check($sformatf("u%0d.chg_cnt", i), o_cnt[i], m_cnt[i]);
                check($sformatf("u%0d.in_ready", i), o_in_ready[i], m_rdy);

                acc_p[i] = o_in_valid[i] && m_rdy;
                if (acc_p[i]) begin
                    acc_y[i]  = model_gate(o_op[i], o_a[i], o_b[i], m_w);
                    acc_ch[i] = (acc_y[i] != m_prev[i]);
                    m_prev[i] = acc_y[i];
                end
                pop_p[i] = m_vis && o_out_ready[i];
                clr_p[i] = o_clr[i];
            end
        end
    end

    // Log of every result taken downstream, for the literal checks.
    logic [7:0]  log_y [2][128];
    logic        log_ch [2][128];
    logic [15:0] log_cnt [2][128];
    int          log_n [2] = '{0, 0};

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (o_out_valid[i] && o_out_ready[i]) begin
                    log_y[i][log_n[i] % 128]   = o_y[i];
                    log_ch[i][log_n[i] % 128]  = o_y_changed[i];
                    log_cnt[i][log_n[i] % 128] = o_cnt[i];
                    log_n[i] = log_n[i] + 1;
                end
            end
        end
    end

    int n_acc [2] = '{0, 0};

    task automatic drive(input int i, input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
        if (i == 0) begin
            bus0.in_valid = v; bus0.a = a; bus0.b = b; bus0.op = op;
        end else begin
            bus1.in_valid = v; bus1.a = a[0]; bus1.b = b[0]; bus1.op = op;
        end
    endtask

    task automatic idle(input int i);
        drive(i, 1'b0, 8'h00, 8'h00, 3'd0);
    endtask

    task automatic set_ordy(input int i, input logic v);
        if (i == 0) bus0.out_ready = v; else bus1.out_ready = v;
    endtask

    task automatic set_clr(input int i, input logic v);
        if (i == 0) bus0.clr_cnt = v; else bus1.clr_cnt = v;
    endtask

    // Called just after a rising edge; returns just after the edge that accepts the beat.
    task automatic send(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic done;
        done = 1'b0;
        drive(i, 1'b1, a, b, op);
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            done = o_in_ready[i];
            @(posedge clk);
            #1;
        end
        check($sformatf("u%0d.accept", i), done, 1'b1);
        if (done) n_acc[i]++;
    endtask

    task automatic drain(input int i);
        for (int t = 0; t < 100 && wr[i] != rd[i]; t++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_pulse(input int i);
        set_clr(i, 1'b1);
        @(posedge clk);
        #1;
        set_clr(i, 1'b0);
        check($sformatf("u%0d.cnt_after_clr", i), o_cnt[i], 16'd0);
    endtask

    task automatic expect_log(input int i, input int pos, input logic [7:0] y, input logic ch);
        check($sformatf("u%0d.log_present[%0d]", i, pos), (log_n[i] > pos), 1'b1);
        check($sformatf("u%0d.log_y[%0d]", i, pos), log_y[i][pos % 128], y);
        check($sformatf("u%0d.log_ch[%0d]", i, pos), log_ch[i][pos % 128], ch);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        logic [7:0] exp_y [8];
        logic       exp_ch [4];
        logic [15:0] exp_cnt [6];
        logic [7:0] y_snap;

        for (int i = 0; i < 2; i++) begin
            idle(i);
            set_ordy(i, 1'b1);
            set_clr(i, 1'b0);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d.rst_out_valid", i), o_out_valid[i], 1'b0);
            check($sformatf("u%0d.rst_y", i), o_y[i], 8'h00);
            check($sformatf("u%0d.rst_y_changed", i), o_y_changed[i], 1'b0);
            check($sformatf("u%0d.rst_chg_cnt", i), o_cnt[i], 16'd0);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // WIDTH=1 NAND stream. A beat accepted at edge N is presented after
        // edge N+1, so downstream takes it at edge N+2.
        base = log_n[1];
        send(1, 8'd0, 8'd0, 3'd2);
        check("u1.lat_not_yet", o_out_valid[1], 1'b0);
        send(1, 8'd0, 8'd1, 3'd2);
        check("u1.lat_valid", o_out_valid[1], 1'b1);
        check("u1.lat_y", o_y[1], 8'd1);
        send(1, 8'd0, 8'd0, 3'd2);
        send(1, 8'd1, 8'd1, 3'd2);
        idle(1);
        drain(1);
        exp_y[0] = 8'd1; exp_y[1] = 8'd1; exp_y[2] = 8'd1; exp_y[3] = 8'd0;
        exp_ch[0] = 1'b1; exp_ch[1] = 1'b0; exp_ch[2] = 1'b0; exp_ch[3] = 1'b1;
        for (int k = 0; k < 4; k++) expect_log(1, base + k, exp_y[k], exp_ch[k]);
        check("u1.nand_chg_cnt", o_cnt[1], 16'd2);

        // All eight ops on F0/3C back-to-back.
        base = log_n[0];
        for (int k = 0; k < 8; k++) send(0, 8'hF0, 8'h3C, 3'(k));
        idle(0);
        drain(0);
        exp_y = '{8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'h0F, 8'hF0};
        for (int k = 0; k < 8; k++) expect_log(0, base + k, exp_y[k], 1'b1);
        check("u0.ops_chg_cnt", o_cnt[0], 16'd8);

        // Backpressure: out_ready low for 5 clocks while a 4-beat BUF stream arrives.
        base = log_n[0];
        n_acc[0] = 0;
        set_ordy(0, 1'b0);
        fork
            begin
                send(0, 8'h11, 8'h00, 3'd7);
                send(0, 8'h22, 8'h00, 3'd7);
                send(0, 8'h33, 8'h00, 3'd7);
                send(0, 8'h44, 8'h00, 3'd7);
                idle(0);
            end
            begin
                repeat (3) @(negedge clk);
                check("u0.bp_in_ready_low", o_in_ready[0], 1'b0);
                check("u0.bp_accepts", n_acc[0], 2);
                check("u0.bp_out_valid", o_out_valid[0], 1'b1);
                y_snap = o_y[0];
                check("u0.bp_y_first", y_snap, 8'h11);
                repeat (2) @(negedge clk);
                check("u0.bp_y_held", o_y[0], 8'h11);
                check("u0.bp_valid_held", o_out_valid[0], 1'b1);
                check("u0.bp_still_stalled", o_in_ready[0], 1'b0);
                @(posedge clk);
                #1;
                set_ordy(0, 1'b1);
            end
        join
        drain(0);
        exp_y[0] = 8'h11; exp_y[1] = 8'h22; exp_y[2] = 8'h33; exp_y[3] = 8'h44;
        for (int k = 0; k < 4; k++) expect_log(0, base + k, exp_y[k], 1'b1);

        // Identical beat three times after a counter clear.
        clr_pulse(0);
        base = log_n[0];
        for (int k = 0; k < 3; k++) send(0, 8'hAA, 8'h55, 3'd4);
        idle(0);
        drain(0);
        exp_ch[0] = 1'b1; exp_ch[1] = 1'b0; exp_ch[2] = 1'b0;
        for (int k = 0; k < 3; k++) expect_log(0, base + k, 8'hFF, exp_ch[k]);
        check("u0.repeat_chg_cnt", o_cnt[0], 16'd1);

        // Saturation on the 2-bit counter with alternating results.
        clr_pulse(1);
        base = log_n[1];
        for (int k = 0; k < 6; k++) send(1, 8'(~k & 1), 8'd0, 3'd7);
        idle(1);
        drain(1);
        exp_cnt = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3};
        for (int k = 0; k < 6; k++)
            check($sformatf("u1.sat_cnt[%0d]", k), log_cnt[1][(base + k) % 128], exp_cnt[k]);

        // Clear in the same cycle the changed result enters the output stage.
        send(1, 8'd1, 8'd0, 3'd7);
        idle(1);
        set_clr(1, 1'b1);
        @(posedge clk);
        #1;
        set_clr(1, 1'b0);
        check("u1.clr_coinc_valid", o_out_valid[1], 1'b1);
        check("u1.clr_coinc_y", o_y[1], 8'd1);
        check("u1.clr_coinc_changed", o_y_changed[1], 1'b1);
        check("u1.clr_coinc_cnt", o_cnt[1], 16'd0);
        drain(1);

        // Reset with both stages of both units full.
        set_ordy(0, 1'b0);
        set_ordy(1, 1'b0);
        send(0, 8'h01, 8'h00, 3'd7);
        send(0, 8'h02, 8'h00, 3'd7);
        idle(0);
        send(1, 8'd0, 8'd0, 3'd7);
        send(1, 8'd1, 8'd0, 3'd7);
        idle(1);
        check("u0.full_in_ready", o_in_ready[0], 1'b0);
        check("u1.full_in_ready", o_in_ready[1], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d.midrst_out_valid", i), o_out_valid[i], 1'b0);
            check($sformatf("u%0d.midrst_chg_cnt", i), o_cnt[i], 16'd0);
        end
        set_ordy(0, 1'b1);
        set_ordy(1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = log_n[0];
        send(0, 8'h00, 8'h00, 3'd0);
        send(0, 8'hF0, 8'h00, 3'd7);
        idle(0);
        drain(0);
        expect_log(0, base, 8'h00, 1'b0);
        expect_log(0, base + 1, 8'hF0, 1'b1);
        check("u0.postrst_chg_cnt", o_cnt[0], 16'd1);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
